// File: rtl/boom_hs_pkg.sv
// Shared types for handshake buffering stages.
package boom_hs_pkg;

  typedef enum logic [1:0] {HS_EMPTY, HS_ONE, HS_FULL} hs_buf_state_e;

  localparam int unsigned HS_BUF_DEPTH = 2;

endpackage

// File: rtl/handshake_if.sv
// Valid/ready handshake bundle carrying a payload of type T.
interface handshake_if #(
  parameter type T = logic [31:0]
) ();

  logic valid;
  logic ready;
  T     data;

  modport sender (output valid, output data, input ready);
  modport receiver (input valid, input data, output ready);

endinterface

// File: rtl/handshake_skid_buf.sv
// Two-entry elastic register slice: registers valid/data forward and ready backward,
// sustaining one transfer per cycle, with a synchronous flush.
module handshake_skid_buf
  import boom_hs_pkg::*;
#(
  parameter type T = logic [31:0]
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  handshake_if.receiver    in_if,
  handshake_if.sender      out_if
);

  T     main_q, main_d;
  T     skid_q, skid_d;
  logic main_v, main_v_d;
  logic skid_v, skid_v_d;
  logic ready_q, ready_d;
  logic in_fire, out_fire;

  hs_buf_state_e state;

  assign out_if.valid = main_v;
  assign out_if.data  = main_q;
  assign in_if.ready  = ready_q;

  assign in_fire  = in_if.valid & ready_q;
  assign out_fire = main_v & out_if.ready;

  always_comb begin
    if (skid_v)      state = HS_FULL;
    else if (main_v) state = HS_ONE;
    else             state = HS_EMPTY;
  end

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v;
    skid_v_d = skid_v;
    unique case (state)
      HS_EMPTY: begin
        if (in_fire) begin
          main_d   = in_if.data;
          main_v_d = 1'b1;
        end
      end
      HS_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_if.data;
        end else if (in_fire) begin
          skid_d   = in_if.data;
          skid_v_d = 1'b1;
        end else if (out_fire) begin
          main_v_d = 1'b0;
        end
      end
      HS_FULL: begin
        if (out_fire) begin
          main_d   = skid_q;
          skid_v_d = 1'b0;
        end
      end
      default: ;
    endcase
    // Flush drops whatever was accepted this cycle; an out_fire already counted as delivered.
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end
    ready_d = !skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q  <= '0;
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      main_q  <= main_d;
      skid_q  <= skid_d;
      main_v  <= main_v_d;
      skid_v  <= skid_v_d;
      ready_q <= ready_d;
    end
  end

  a_no_skid_only: assert property (@(posedge clk) disable iff (!rst_n)
    !(skid_v && !main_v));

  a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (main_v && !out_if.ready) |=> $stable(main_q));

  a_not_ready_full: assert property (@(posedge clk) disable iff (!rst_n)
    !((state == HS_FULL) && ready_q));

endmodule

// File: tb/tb_handshake_skid_buf.sv
// Directed-vector and scoreboard bench for handshake_skid_buf.
module tb_handshake_skid_buf;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        f;
    logic        ev;
    logic [31:0] ed;
    logic        er;
  } vec_t;

  logic clk;
  logic rst_n;
  logic flush;

  int checks;
  int errors;

  vec_t        vecs[$];
  logic [31:0] model_q[$];

  handshake_if #(.T(logic [31:0])) in_if ();
  handshake_if #(.T(logic [31:0])) out_if ();

  handshake_skid_buf #(.T(logic [31:0])) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .in_if   (in_if),
    .out_if  (out_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic v, input logic [31:0] d, input logic r, input logic f,
                              input logic ev, input logic [31:0] ed, input logic er);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.f = f; t.ev = ev; t.ed = ed; t.er = er;
    vecs.push_back(t);
  endfunction

  // Drive one cycle and check against a queue model of the buffer contents.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    logic in_fire_m, out_fire_m;
    in_if.valid  = v;
    in_if.data   = d;
    out_if.ready = r;
    flush        = f;
    in_fire_m  = v && (model_q.size() < 2);
    out_fire_m = r && (model_q.size() > 0);
    if (out_fire_m) void'(model_q.pop_front());
    if (f) model_q.delete();
    else if (in_fire_m) model_q.push_back(d);
    @(posedge clk);
    #1;
    chk("model_valid", {31'd0, out_if.valid}, {31'd0, model_q.size() > 0});
    chk("model_ready", {31'd0, in_if.ready}, {31'd0, model_q.size() < 2});
    if (model_q.size() > 0) chk("model_data", out_if.data, model_q[0]);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, out_if.valid}, 32'd0);
      chk("rst_ready", {31'd0, in_if.ready}, 32'd0);
    end
    chk("rst_data", out_if.data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", {31'd0, in_if.ready}, 32'd1);
    chk("rel_valid", {31'd0, out_if.valid}, 32'd0);

    // Back-to-back streaming 0x1..0x10.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 32'(i), 1'b1, 1'b0);
      chk("stream_data", out_if.data, 32'(i));
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // v, d, r, f, exp_valid, exp_data, exp_ready (data checked only when valid expected)
    add(1, 32'h55, 0, 0, 1, 32'h55, 1);
    add(1, 32'h66, 0, 0, 1, 32'h55, 0);
    add(1, 32'h99, 0, 0, 1, 32'h55, 0);
    add(0, 32'h00, 1, 0, 1, 32'h66, 1);
    add(0, 32'h00, 1, 0, 0, 32'h00, 1);
    add(1, 32'h11, 0, 0, 1, 32'h11, 1);
    add(1, 32'h22, 0, 0, 1, 32'h11, 0);
    add(1, 32'h77, 0, 1, 0, 32'h00, 1);
    add(0, 32'h00, 1, 0, 0, 32'h00, 1);
    add(1, 32'h33, 0, 0, 1, 32'h33, 1);
    add(1, 32'h44, 1, 1, 0, 32'h00, 1);
    add(0, 32'h00, 1, 0, 0, 32'h00, 1);
    add(1, 32'h50, 1, 0, 1, 32'h50, 1);
    add(1, 32'h51, 1, 0, 1, 32'h51, 1);
    add(0, 32'h00, 1, 0, 0, 32'h00, 1);
    add(1, 32'hA0, 1, 0, 1, 32'hA0, 1);
    add(1, 32'hA1, 1, 0, 1, 32'hA1, 1);
    add(1, 32'hA2, 1, 0, 1, 32'hA2, 1);
    add(1, 32'hA3, 0, 0, 1, 32'hA2, 0);
    add(1, 32'hA4, 0, 0, 1, 32'hA2, 0);
    add(1, 32'hA4, 0, 0, 1, 32'hA2, 0);
    add(1, 32'hA4, 0, 0, 1, 32'hA2, 0);
    add(1, 32'hA4, 1, 0, 1, 32'hA3, 1);
    add(1, 32'hA4, 1, 0, 1, 32'hA4, 1);
    add(1, 32'hA5, 1, 0, 1, 32'hA5, 1);
    add(1, 32'hA6, 1, 0, 1, 32'hA6, 1);
    add(1, 32'hA7, 1, 0, 1, 32'hA7, 1);
    add(0, 32'h00, 1, 0, 0, 32'h00, 1);

    foreach (vecs[i]) begin
      in_if.valid  = vecs[i].v;
      in_if.data   = vecs[i].d;
      out_if.ready = vecs[i].r;
      flush        = vecs[i].f;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, out_if.valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_ready", i), {31'd0, in_if.ready}, {31'd0, vecs[i].er});
      if (vecs[i].ev) chk($sformatf("vec%0d_data", i), out_if.data, vecs[i].ed);
    end

    // Random valid/ready against the queue model; payload is a running count.
    model_q.delete();
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 32'h1000 + 32'(i), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("drained", {31'd0, out_if.valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_skid_buf.md
# handshake_skid_buf

Two-entry elastic register slice placed between a `handshake_if` sender and receiver. It breaks every combinational path through the handshake: data/valid forward and ready backward. It keeps full throughput of one transfer per cycle. It carries a synchronous flush for pipeline redirects, and sits at stage boundaries wherever timing closure needs a registered cut.

## Interface
- `T`, default `logic[31:0]`: payload type, identical to the `handshake_if` type parameter on both ports.
- `clk`  input  1: single clock; all state updates on rising edge.
- `rst_n`  input  1: reset, synchronous, active-low.
- `flush_i`  input  1: synchronous flush; discards all buffered entries.
- `in_if`  `handshake_if.receiver`  `$bits(T)`+2: upstream side; drives `ready`, samples `valid`/`data`.
- `out_if`  `handshake_if.sender`  `$bits(T)`+2: downstream side; drives `valid`/`data`, samples `ready`.

## Operation
- Storage: main register (`main_q`, `main_v`) and skid register (`skid_q`, `skid_v`).
- `out_if.valid = main_v`, `out_if.data = main_q`, `in_if.ready = ready_q`. All three are driven directly from flops.
- `in_fire = in_if.valid & in_if.ready`; `out_fire = out_if.valid & out_if.ready`.
- States, encoded from (main_v, skid_v):
  - EMPTY (0,0)
  - ONE (1,0)
  - FULL (1,1)
  - (0,1) is illegal and never reached.
- EMPTY: on `in_fire`, main <= in data, go to ONE.
- ONE:
  - `in_fire` & `out_fire`: main <= in data, stay ONE.
  - `in_fire` only: skid <= in data, go to FULL.
  - `out_fire` only: go to EMPTY.
  - Neither: hold.
- FULL: `in_if.ready` is 0, so no `in_fire` is possible. On `out_fire`, main <= skid, skid_v <= 0, go to ONE.
- `ready_q` next value is `!skid_v_next`. It is 0 only while the next state is FULL.
- Ordering: FIFO. The skid entry is always younger than the main entry.
- Flush (`flush_i`=1 at an edge):
  - Next state is EMPTY and `ready_q` becomes 1.
  - Any `in_fire` in the flush cycle is dropped.
  - `out_fire` in the flush cycle counts as delivered, because the downstream has already sampled it.
  - Flush has priority over every transition.
- Reset (`rst_n`=0 at an edge):
  - `main_v`=0, `skid_v`=0, `ready_q`=0, `main_q`='0.
  - `skid_q` is not reset.
  - On the first edge with `rst_n`=1, `ready_q` becomes 1. Reset overrides flush.
- Reset mid-operation: all entries are lost. No output glitches, because outputs come from flops.
- `out_if.data` must stay stable while `out_if.valid`=1 and `out_if.ready`=0. The upstream is not required to hold data while ready=0.

## Timing
- Latency: 1 cycle. A transfer accepted at edge N is visible at `out_if` after edge N.
- Throughput: 1 transfer per cycle sustained while the downstream keeps ready=1.
- Backpressure: the downstream drops ready in cycle N.
  - One more input can still be accepted at edge N, into skid.
  - `in_if.ready` is then low from N+1.
- Recovery from FULL: downstream ready=1 at edge M gives `in_if.ready`=1 after M.
- No combinational path from any input to any output.
- Reset values after the reset edge:
  - `out_if.valid`=0
  - `out_if.data`='0
  - `in_if.ready`=0, rising to 1 one cycle after release.

## Structure
- Shared package `boom_hs_pkg`:
  - `typedef enum logic[1:0] {HS_EMPTY, HS_ONE, HS_FULL} hs_buf_state_e`, used for debug visibility and assertions.
  - `HS_BUF_DEPTH = 2` as a localparam.
- No sub-module. It is a single flat module with one `always_ff` block and one next-state `always_comb` block.
- Assertions inside the module:
  - The (0,1) encoding is never reached.
  - `out_if.data` is stable under stall.
  - `in_if.ready`=0 in FULL.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release. Expect `out_if.valid`=0 and `in_if.ready`=0 through reset, then `in_if.ready`=1 one cycle after release.
- Streaming: send 0x1..0x10 back-to-back with downstream ready=1. Expect the same 16 values in order, 1-cycle latency, no bubbles.
- Backpressure: stream 0xA0..0xA7 and drop downstream ready for 4 cycles after 0xA2 is shown. Expect:
  - `in_if.ready` low from the second stall cycle.
  - `out_if.data` held at 0xA2.
  - Skid holds 0xA3.
  - Order is preserved after release.
  - Nothing is lost or duplicated.
- FULL drain: fill with 0x55 then 0x66 while the downstream is stalled, then assert ready for 2 cycles. Expect 0x55, then 0x66, then valid=0, with `in_if.ready` back to 1 after the first drain edge.
- Flush: in FULL, assert `flush_i` for one cycle while upstream offers 0x77. Expect `out_if.valid`=0 and `in_if.ready`=1 next cycle, and 0x77 never appears downstream.
- Random: random valid/ready toggling at 50% for 10k cycles against a scoreboard. Expect in-order, lossless delivery with zero assertion failures.
